// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: splits a W = N*K bit add into K slice adds on an external
// registered N-bit adder, chaining carries LSB-first, then returns the W-bit sum
// and final carry over a valid/ready handshake.
module wide_add_sequencer #(
  parameter int N       = 4,
  parameter int K       = 4,
  parameter int ADD_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  // operand side
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*K-1:0]   in_a,
  input  logic [N*K-1:0]   in_b,
  input  logic             in_cin,
  // result side
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*K-1:0]   out_sum,
  output logic             out_cout,
  // slice adder side
  output logic [N-1:0]     add_a,
  output logic [N-1:0]     add_b,
  output logic             add_cin,
  input  logic [N-1:0]     add_sum,
  input  logic             add_cout
);

  localparam int W  = N * K;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int CW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q;
  logic [W-1:0]    op_a_q;
  logic [W-1:0]    op_b_q;
  logic            carry_q;
  logic [KW-1:0]   k_q;
  logic [CW-1:0]   cnt_q;
  logic [N-1:0]    res_sl_q [K];
  logic            res_cout_q;
  logic            in_ready_q;
  logic            out_valid_q;

  // Slice views of the captured operands, indexed by the current slice number.
  logic [N-1:0]    a_sl [K];
  logic [N-1:0]    b_sl [K];

  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_slice
      assign a_sl[gi]               = op_a_q[gi*N +: N];
      assign b_sl[gi]               = op_b_q[gi*N +: N];
      assign out_sum[gi*N +: N]     = res_sl_q[gi];
    end
  endgenerate

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_cout  = res_cout_q;

  // Adder inputs are only non-zero during the single issue cycle of a slice.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state_q == S_ISSUE) begin
      add_a   = a_sl[k_q];
      add_b   = b_sl[k_q];
      add_cin = carry_q;
    end
  end

  // Sequencer FSM: accept, issue/wait per slice, collect results, hand off.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      carry_q     <= 1'b0;
      k_q         <= '0;
      cnt_q       <= '0;
      res_cout_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      for (int i = 0; i < K; i++) begin
        res_sl_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_a_q     <= in_a;
            op_b_q     <= in_b;
            carry_q    <= in_cin;
            k_q        <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // The adder output for this slice is valid only in the last wait cycle.
          if (cnt_q == CW'(ADD_LAT - 1)) begin
            res_sl_q[k_q] <= add_sum;
            carry_q       <= add_cout;
            if (k_q == KW'(K - 1)) begin
              res_cout_q  <= add_cout;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              k_q     <= k_q + 1'b1;
              state_q <= S_ISSUE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/wide_add_sequencer.md
# wide_add_sequencer

Front-end sequencer for the registered N-bit ripple-carry adder stage. It accepts one wide operand pair (W = N×K bits) per transaction over a valid/ready handshake. It splits the operands into K slices of N bits, feeds them LSB-first to the adder, and chains each slice's carry-out into the next slice's carry-in. It reassembles the W-bit sum and final carry, then presents them on an output valid/ready handshake.

## Interface
- N, 4: slice width; must equal the adder's N.
- K, 4: number of slices; W = N×K. K ≥ 1.
- ADD_LAT, 2: adder register depth (input regs + output regs). ≥ 1.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_cin  in  1  carry-in of the wide add.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  W  A + B + cin, modulo 2^W.
- out_cout  out  1  carry-out of bit W-1.
- add_a  out  N  slice A to adder.
- add_b  out  N  slice B to adder.
- add_cin  out  1  carry-in to adder.
- add_sum  in  N  adder sum output (registered in adder).
- add_cout  in  1  adder carry output (registered in adder).

## Operation
- States: IDLE, ISSUE, WAIT, DONE. Registers: op_a, op_b (W), carry (1), slice index k (0..K-1), wait counter (0..ADD_LAT-1), res (W), res_cout.
- IDLE: in_ready=1. On in_valid&in_ready: op_a<=in_a, op_b<=in_b, carry<=in_cin, k<=0, go to ISSUE.
- ISSUE (1 cycle): add_a=op_a[k*N +: N], add_b=op_b[k*N +: N], add_cin=carry. Go to WAIT with the counter cleared.
- WAIT (ADD_LAT cycles): add_* = 0.
  - In the last WAIT cycle: res[k*N +: N]<=add_sum and carry<=add_cout.
  - If k==K-1, also res_cout<=add_cout and go to DONE. Otherwise k<=k+1 and go to ISSUE.
- DONE: out_valid=1, with out_sum=res and out_cout=res_cout held stable. On out_ready go to IDLE.
- Outside ISSUE, add_a/add_b/add_cin are driven 0. They are combinational from state and registers.
- in_ready is 0 in ISSUE, WAIT and DONE. in_valid in those states is ignored and nothing is captured.
- Arithmetic is unsigned. The carry propagates only through the adder; the sequencer does no addition itself.
- K=1 degenerates to one ISSUE+WAIT pass, and out_cout equals the adder's cout.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_cout=0, add_a=0, add_b=0, add_cin=0, and all internal registers 0.
- Cycle 0 is the acceptance cycle.
- Slice k is issued in cycle 1 + k·(ADD_LAT+1). Its result is sampled at the edge ending cycle 1 + k·(ADD_LAT+1) + ADD_LAT.
- out_valid first asserts in cycle 1 + K·(ADD_LAT+1). With the defaults, that is cycle 13.
- in_ready reasserts in the cycle after the out_valid&out_ready handshake. Throughput is one transaction per K·(ADD_LAT+1)+2 cycles minimum; 14 cycles with the defaults.
- Back-pressure: DONE holds indefinitely with stable outputs while out_ready=0.
- Reset mid-transaction: next cycle is IDLE with all outputs at reset values, and the partial result is discarded. The adder shares the reset, so no stale adder output is sampled afterwards.
- Reset together with in_valid: reset wins and nothing is accepted.

## Test plan
- Plain add: in_a=0x1234, in_b=0x0001, cin=0 → out_sum=0x1235, out_cout=0, with out_valid first in cycle 13.
- Full carry ripple: 0xFFFF + 0x0001, cin=0 → out_sum=0x0000, out_cout=1. The bench checks add_cin=1 at the issue of slices 1, 2 and 3.
- Carry-in only: 0xFFFF + 0x0000, cin=1 → 0x0000, cout=1. Also 0x8000 + 0x8000, cin=0 → 0x0000, cout=1.
- Back-pressure and busy input: hold out_ready=0 for 5 cycles → out_sum/out_cout stay stable. Drive in_valid continuously with changing data while busy → only the first operand pair is processed, and the next is accepted only after returning to IDLE.
- Reset mid-op: assert reset in cycle 6 of a transaction → out_valid stays 0, add_* go to 0, and in_ready=1 the cycle after. A fresh 0x00FF+0x0001 then yields 0x0100, cout=0.
- Random regression: 200 random W-bit pairs and cin, compared against the (W+1)-bit reference sum, with random out_ready stalls.
